wb_des_ctrl: RTL and testbench

WB_DES_CTRL -- requirements
Module: wb_des_ctrl

---
 rtl/des_ctrl_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/wb_des_ctrl.sv | 125 ++++++++++++
 tb/tb_wb_des_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_ctrl_pkg.sv
// Shared register map and field layout for the design-select controller.
package des_ctrl_pkg;

  // Word index within the 16-byte register window (adr[3:2]).
  typedef enum logic [1:0] {
    RegCtrl = 2'd0,
    RegSel  = 2'd1,
    RegIn   = 2'd2,
    RegOut  = 2'd3
  } reg_idx_e;

  // CTRL bit positions.
  localparam int unsigned CtrlOverride = 0;
  localparam int unsigned CtrlHold     = 1;
  localparam int unsigned CtrlSync     = 2;
  localparam int unsigned CtrlSoftRst  = 3;

  // Field widths.
  localparam int unsigned SelWidth = 6;
  localparam int unsigned PinWidth = 12;

  // Stored CTRL bits; soft_rst is a strobe and is not stored.
  typedef struct packed {
    logic sync;
    logic hold;
    logic override;
  } ctrl_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for bringing a bus into the wb_clk_i domain.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q, sync_q;

  // Two-stage capture; only the second stage is consumed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/wb_des_ctrl.sv
// Wishbone register block selecting and driving one of several user designs.
module wb_des_ctrl
  import des_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [5:0]  pin_sel_i,
  input  logic        pin_hold_i,
  input  logic        pin_sync_i,
  input  logic        pin_reset_i,
  input  logic [11:0] pin_in_i,
  input  logic [11:0] des_out_i,
  output logic [5:0]  des_sel_o,
  output logic        des_hold_o,
  output logic        des_sync_o,
  output logic        des_reset_o,
  output logic [11:0] des_in_o
);

  ctrl_t                ctrl_q, ctrl_d;
  logic [SelWidth-1:0]  sel_q, sel_d;
  logic [PinWidth-1:0]  in_q, in_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;
  logic [PinWidth-1:0]  out_sync;
  logic [31:0]          rdata;
  logic                 hit, req, wr;
  reg_idx_e             idx;
  logic                 unused_bits;

  assign hit = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // Blocking a request while ack is high guarantees no back-to-back acks.
  assign req = hit & ~ack_q;
  assign wr  = req & wbs_we_i;
  assign idx = reg_idx_e'(wbs_adr_i[3:2]);

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:12], wbs_sel_i[3:2]};

  sync_2ff #(
    .Width(PinWidth)
  ) u_out_sync (
    .clk_i(wb_clk_i),
    .rst_i(wb_rst_i),
    .d_i  (des_out_i),
    .q_o  (out_sync)
  );

  // Read mux; undefined bits read as zero.
  always_comb begin
    rdata = '0;
    case (idx)
      RegCtrl: rdata = {29'b0, ctrl_q};
      RegSel:  rdata = {{(32 - SelWidth){1'b0}}, sel_q};
      RegIn:   rdata = {{(32 - PinWidth){1'b0}}, in_q};
      RegOut:  rdata = {{(32 - PinWidth){1'b0}}, out_sync};
      default: rdata = '0;
    endcase
  end

  // Register writes, soft-reset counter and bus response next state.
  always_comb begin
    ctrl_d = ctrl_q;
    sel_d  = sel_q;
    in_d   = in_q;
    cnt_d  = (cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    ack_d  = req;
    dat_d  = (req && !wbs_we_i) ? rdata : '0;
    if (wr && wbs_sel_i[0]) begin
      case (idx)
        RegCtrl: begin
          ctrl_d.override = wbs_dat_i[CtrlOverride];
          ctrl_d.hold     = wbs_dat_i[CtrlHold];
          ctrl_d.sync     = wbs_dat_i[CtrlSync];
          // Reload even when already counting so the pulse only extends.
          if (wbs_dat_i[CtrlSoftRst]) cnt_d = 8'(RST_CYCLES);
        end
        RegSel:  sel_d = wbs_dat_i[SelWidth-1:0];
        RegIn:   in_d[7:0] = wbs_dat_i[7:0];
        default: ;
      endcase
    end
    if (wr && wbs_sel_i[1] && (idx == RegIn)) in_d[11:8] = wbs_dat_i[11:8];
  end

  // State registers; reset aborts any transaction in flight.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl_q <= '0;
      sel_q  <= '0;
      in_q   <= '0;
      cnt_q  <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      sel_q  <= sel_d;
      in_q   <= in_d;
      cnt_q  <= cnt_d;
      ack_q  <= ack_d;
      dat_q  <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  assign des_sel_o   = ctrl_q.override ? sel_q       : pin_sel_i;
  assign des_hold_o  = ctrl_q.override ? ctrl_q.hold : pin_hold_i;
  assign des_sync_o  = ctrl_q.override ? ctrl_q.sync : pin_sync_i;
  assign des_in_o    = ctrl_q.override ? in_q        : pin_in_i;
  assign des_reset_o = pin_reset_i | (cnt_q != 8'd0);

endmodule

// File: tb/tb_wb_des_ctrl.sv
// Directed bench for wb_des_ctrl: register vector table plus timing sequences.
module tb_wb_des_ctrl;

  localparam logic [31:0] Base = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [5:0]  pin_sel;
  logic        pin_hold, pin_sync, pin_reset;
  logic [11:0] pin_in, des_out;
  logic [5:0]  des_sel;
  logic        des_hold, des_sync, des_reset;
  logic [11:0] des_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_des_ctrl #(
    .BASE_ADDR (Base),
    .RST_CYCLES(16)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .pin_sel_i  (pin_sel),
    .pin_hold_i (pin_hold),
    .pin_sync_i (pin_sync),
    .pin_reset_i(pin_reset),
    .pin_in_i   (pin_in),
    .des_out_i  (des_out),
    .des_sel_o  (des_sel),
    .des_hold_o (des_hold),
    .des_sync_o (des_sync),
    .des_reset_o(des_reset),
    .des_in_o   (des_in)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        exp_ack;
    logic [31:0] exp_rdata;
    logic [11:0] exp_in;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic bus_drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
  endtask

  task automatic bus_idle();
    stb = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
  endtask

  // One transaction, bounded to 4 cycles; called and returns at posedge+1.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic acked, output logic [31:0] rd,
                      output int lat);
    bus_drive(w, a, d, s);
    acked = 1'b0; rd = '0; lat = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1; rd = rdat; lat = i;
        break;
      end
    end
    bus_idle();
    @(posedge clk); #1;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic        acked;
    logic [31:0] rd;
    int          lat;
    xfer(1'b0, a, 32'h0, 4'hF, acked, rd, lat);
    check({name, "_ack"}, {31'b0, acked}, 32'd1);
    check(name, rd, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic        acked;
    logic [31:0] rd;
    int          lat;
    xfer(1'b1, a, d, s, acked, rd, lat);
    check("wr_ack", {31'b0, acked}, 32'd1);
  endtask

  // Count consecutive clocks des_reset_o stays high, starting from 1.
  task automatic count_high(output int high);
    high = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!des_reset) break;
      high++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic        acked;
    logic [31:0] rd;
    int          lat, high, nack, adj, nz;
    logic        prev, glitch;

    vecs[0]  = '{"rst_ctrl",  1'b0, Base + 32'h0, 32'h0,         4'hF, 1'b1, 32'h0,  12'h5A5};
    vecs[1]  = '{"rst_sel",   1'b0, Base + 32'h4, 32'h0,         4'hF, 1'b1, 32'h0,  12'h5A5};
    vecs[2]  = '{"rst_in",    1'b0, Base + 32'h8, 32'h0,         4'hF, 1'b1, 32'h0,  12'h5A5};
    vecs[3]  = '{"wr_sel",    1'b1, Base + 32'h4, 32'h0000_002A, 4'h1, 1'b1, 32'h0,  12'h5A5};
    vecs[4]  = '{"wr_ovr",    1'b1, Base + 32'h0, 32'h0000_0001, 4'h1, 1'b1, 32'h0,  12'h000};
    vecs[5]  = '{"rd_sel",    1'b0, Base + 32'h4, 32'h0,         4'hF, 1'b1, 32'h2A, 12'h000};
    vecs[6]  = '{"wr_in_l0",  1'b1, Base + 32'h8, 32'hFFFF_FFFF, 4'h1, 1'b1, 32'h0,  12'h0FF};
    vecs[7]  = '{"rd_in",     1'b0, Base + 32'h8, 32'h0,         4'hF, 1'b1, 32'hFF, 12'h0FF};
    vecs[8]  = '{"wr_sel_hi", 1'b1, Base + 32'h4, 32'hFFFF_FFFF, 4'hE, 1'b1, 32'h0,  12'h0FF};
    vecs[9]  = '{"rd_sel2",   1'b0, Base + 32'h4, 32'h0,         4'hF, 1'b1, 32'h2A, 12'h0FF};
    vecs[10] = '{"wr_ctrl7",  1'b1, Base + 32'h0, 32'hFFFF_FFF7, 4'h1, 1'b1, 32'h0,  12'h0FF};
    vecs[11] = '{"rd_ctrl",   1'b0, Base + 32'h0, 32'h0,         4'hF, 1'b1, 32'h7,  12'h0FF};
    vecs[12] = '{"wr_out",    1'b1, Base + 32'hC, 32'h0000_0FFF, 4'hF, 1'b1, 32'h0,  12'h0FF};
    vecs[13] = '{"rd_out",    1'b0, Base + 32'hC, 32'h0,         4'hF, 1'b1, 32'h0,  12'h0FF};
    vecs[14] = '{"rd_miss",   1'b0, Base + 32'h20, 32'h0,        4'hF, 1'b0, 32'h0,  12'h0FF};
    vecs[15] = '{"wr_in_l1",  1'b1, Base + 32'h8, 32'h0000_0A00, 4'h2, 1'b1, 32'h0,  12'hAFF};
    vecs[16] = '{"rd_in2",    1'b0, Base + 32'h8, 32'h0,         4'hF, 1'b1, 32'hAFF, 12'hAFF};

    rst = 1'b1;
    bus_idle();
    pin_sel = 6'h11; pin_hold = 1'b0; pin_sync = 1'b1; pin_reset = 1'b0;
    pin_in = 12'h5A5; des_out = 12'h000;

    // Reset state.
    #12;
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_dat", rdat, 32'h0);
    check("rst_des_reset", {31'b0, des_reset}, 32'd0);
    check("rst_des_sel", {26'b0, des_sel}, {26'b0, pin_sel});
    check("rst_des_in", {20'b0, des_in}, {20'b0, pin_in});
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Register map vectors.
    for (int v = 0; v < 17; v++) begin
      xfer(vecs[v].we, vecs[v].addr, vecs[v].data, vecs[v].sel, acked, rd, lat);
      check({vecs[v].name, "_ack"}, {31'b0, acked}, {31'b0, vecs[v].exp_ack});
      if (vecs[v].exp_ack) check({vecs[v].name, "_lat"}, lat, 32'd1);
      check({vecs[v].name, "_data"}, rd, vecs[v].exp_rdata);
      check({vecs[v].name, "_des_in"}, {20'b0, des_in}, {20'b0, vecs[v].exp_in});
    end

    // Override on: outputs from registers.
    check("ovr_sel", {26'b0, des_sel}, 32'h2A);
    check("ovr_hold", {31'b0, des_hold}, 32'd1);
    check("ovr_sync", {31'b0, des_sync}, 32'd1);
    // Override off: outputs follow pins.
    pin_sync = 1'b0;
    wr(Base, 32'h0, 4'h1);
    check("pin_sel", {26'b0, des_sel}, 32'h11);
    check("pin_in", {20'b0, des_in}, 32'h5A5);
    check("pin_sync", {31'b0, des_sync}, 32'd0);

    // OUT synchroniser: a read launched with the step still sees the old value.
    des_out = 12'hABC;
    rd_check("out_early", Base + 32'hC, 32'h0);
    rd_check("out_late", Base + 32'hC, 32'hABC);

    // Soft reset pulse length.
    bus_drive(1'b1, Base, 32'h8, 4'h1);
    @(posedge clk); #1;
    check("pulse_ack", {31'b0, ack}, 32'd1);
    check("pulse_start", {31'b0, des_reset}, 32'd1);
    bus_idle();
    count_high(high);
    check("pulse_len", high, 32'd16);

    // Rewrite at clock 10 extends by a fresh 16 clocks without dropping.
    bus_drive(1'b1, Base, 32'h8, 4'h1);
    @(posedge clk); #1;
    bus_idle();
    glitch = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (!des_reset) glitch = 1'b1;
    end
    bus_drive(1'b1, Base, 32'h8, 4'h1);
    @(posedge clk); #1;
    check("reload_ack", {31'b0, ack}, 32'd1);
    bus_idle();
    count_high(high);
    check("reload_len", high, 32'd16);
    check("reload_glitch", {31'b0, glitch}, 32'd0);

    // Out-of-window address held 5 cycles: no ack, no write.
    bus_drive(1'b1, Base + 32'h10, 32'h7, 4'hF);
    nack = 0; nz = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack) nack++;
      if (rdat != 32'h0) nz++;
    end
    bus_idle();
    @(posedge clk); #1;
    check("miss_acks", nack, 32'd0);
    check("miss_dat", nz, 32'd0);
    rd_check("miss_ctrl", Base, 32'h0);

    // Held strobe on a hit: acks alternate, data zero outside ack cycles.
    bus_drive(1'b0, Base + 32'h4, 32'h0, 4'hF);
    nack = 0; adj = 0; nz = 0; prev = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack) begin
        nack++;
        if (prev) adj++;
      end else if (rdat != 32'h0) begin
        nz++;
      end
      prev = ack;
    end
    bus_idle();
    @(posedge clk); #1;
    check("held_acks", nack, 32'd4);
    check("held_adjacent", adj, 32'd0);
    check("held_idle_dat", nz, 32'd0);

    // Reset mid-pulse and mid-write.
    wr(Base + 32'h4, 32'h15, 4'h1);
    wr(Base, 32'h9, 4'h1);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_pulse", {31'b0, des_reset}, 32'd1);
    bus_drive(1'b1, Base + 32'h4, 32'h3F, 4'h1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ack", {31'b0, ack}, 32'd0);
    check("arst_des_reset", {31'b0, des_reset}, 32'd0);
    check("arst_des_sel", {26'b0, des_sel}, 32'h11);
    @(posedge clk); #1;
    check("arst_ack_edge", {31'b0, ack}, 32'd0);
    pin_reset = 1'b1;
    #1;
    check("arst_pin_reset", {31'b0, des_reset}, 32'd1);
    pin_reset = 1'b0;
    bus_idle();
    rst = 1'b0;
    @(posedge clk); #1;
    rd_check("post_rst_ctrl", Base, 32'h0);
    rd_check("post_rst_sel", Base + 32'h4, 32'h0);
    rd_check("post_rst_in", Base + 32'h8, 32'h0);
    check("post_rst_des_reset", {31'b0, des_reset}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
